jts16_scr_sdram_slot: RTL

SDRAM responder serving the map and tile-pixel fetch ports of a scroll tile layer. Accepts the layer's `map_addr`/`scr_addr` requests, fetches 16-bit map words and 32-bit tile words over one shared SDRAM request port, and returns data qualified by `map_ok`/`scr_ok`. It holds one cached entry per client, so a repeated address answers without SDRAM traffic. It sits between the tile layer and the SDRAM controller.

---
 rtl/jts16_scr_sdram_slot.sv | 120 ++++++++++++
 1 files changed

// File: rtl/jts16_scr_sdram_slot.sv
// SDRAM slot for a scroll tile layer. It serves 16-bit map words and 32-bit tile words
// through one SDRAM request port and keeps one cached entry per client.
// Optional build macro JTS16_SLOT_STATS_EN enables the saturating fetch counter on fetch_cnt.
module jts16_scr_sdram_slot #(
    parameter logic [21:0] MAP_OFFSET = 22'h0,
    parameter logic [21:0] SCR_OFFSET = 22'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] map_addr,
    output logic [15:0] map_data,
    output logic        map_ok,
    input  logic [16:0] scr_addr,
    output logic [31:0] scr_data,
    output logic        scr_ok,
    output logic [21:0] sdram_addr,
    output logic        sdram_req,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    input  logic [15:0] sdram_din,
    output logic [15:0] fetch_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, DATA0, DATA1} state_t;

    state_t      st;
    logic        sel_scr;
    logic        map_valid, scr_valid;
    logic [13:0] map_tag, map_tag_pend;
    logic [15:0] scr_tag, scr_tag_pend;
    logic        unused_scr_lsb;

    // The tile fetch always starts on an even word, so the address LSB is dropped.
    assign unused_scr_lsb = scr_addr[0];

    assign map_ok = map_valid & (map_addr == map_tag);
    assign scr_ok = scr_valid & (scr_addr[16:1] == scr_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= IDLE;
            sel_scr      <= 1'b0;
            map_valid    <= 1'b0;
            scr_valid    <= 1'b0;
            map_tag      <= '0;
            map_tag_pend <= '0;
            scr_tag      <= '0;
            scr_tag_pend <= '0;
            map_data     <= '0;
            scr_data     <= '0;
            sdram_addr   <= '0;
            sdram_req    <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    // Map has fixed priority over the tile client
                    if (!map_ok) begin
                        map_tag_pend <= map_addr;
                        sel_scr      <= 1'b0;
                        sdram_addr   <= MAP_OFFSET + {8'd0, map_addr};
                        sdram_req    <= 1'b1;
                        st           <= REQ;
                    end else if (!scr_ok) begin
                        scr_tag_pend <= scr_addr[16:1];
                        sel_scr      <= 1'b1;
                        sdram_addr   <= SCR_OFFSET + {5'd0, scr_addr[16:1], 1'b0};
                        sdram_req    <= 1'b1;
                        st           <= REQ;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        st        <= DATA0;
                    end
                end
                DATA0: begin
                    if (sdram_rdy) begin
                        if (sel_scr) begin
                            scr_data[15:0] <= sdram_din;
                            st             <= DATA1;
                        end else begin
                            // Commits the pending tag even if map_addr has moved on
                            map_data  <= sdram_din;
                            map_tag   <= map_tag_pend;
                            map_valid <= 1'b1;
                            st        <= IDLE;
                        end
                    end
                end
                DATA1: begin
                    if (sdram_rdy) begin
                        scr_data[31:16] <= sdram_din;
                        scr_tag         <= scr_tag_pend;
                        scr_valid       <= 1'b1;
                        st              <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

`ifdef JTS16_SLOT_STATS_EN
    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (st == REQ && sdram_ack && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign fetch_cnt = cnt;
`else
    assign fetch_cnt = 16'h0000;
`endif

endmodule
